// File: rtl/fp16_max4_pool.sv
// Registered 4-input fp16 max unit for 2x2 max-pooling, with a standalone
// registered fp16 comparator sharing the same compare core.
module fp16_max4_pool #(
  parameter logic [15:0] NAN_OUT = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] n1,
  input  logic [15:0] n2,
  input  logic [15:0] n3,
  input  logic [15:0] n4,
  output logic        out_valid,
  output logic [15:0] max_out,
  input  logic [15:0] cmp_a,
  input  logic [15:0] cmp_b,
  output logic        a_gt_b,
  output logic        a_eq_b
);

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  // Returns {gt, eq}. Sign-magnitude ordering: for two negatives the smaller
  // magnitude is the greater value.
  function automatic logic [1:0] fp16_cmp(input logic [15:0] x, input logic [15:0] y);
    logic gt;
    logic eq;
    gt = 1'b0;
    eq = 1'b0;
    if (is_nan(x) || is_nan(y)) begin
      gt = 1'b0;
      eq = 1'b0;
    end else if ((x[14:0] == 15'd0) && (y[14:0] == 15'd0)) begin
      gt = 1'b0;
      eq = 1'b1;
    end else begin
      eq = (x == y);
      if (x[15] != y[15])
        gt = ~x[15];
      else if (!x[15])
        gt = x[14:0] > y[14:0];
      else
        gt = x[14:0] < y[14:0];
    end
    return {gt, eq};
  endfunction

  // Ties keep x untouched, so lower-index operands win bit-exact.
  function automatic logic [15:0] fp16_max2(input logic [15:0] x, input logic [15:0] y);
    logic [1:0] c;
    c = fp16_cmp(y, x);
    if (!is_nan(y) && (is_nan(x) || c[1]))
      return y;
    return x;
  endfunction

  logic        out_valid_q, out_valid_d;
  logic [15:0] max_q, max_d;
  logic        gt_q, gt_d;
  logic        eq_q, eq_d;
  logic [15:0] m12, m34, m_all;
  logic [1:0]  cmp_res;

  always_comb begin
    m12   = fp16_max2(n1, n2);
    m34   = fp16_max2(n3, n4);
    m_all = fp16_max2(m12, m34);
    // A NaN survives the tree only when every input was NaN.
    max_d = is_nan(m_all) ? NAN_OUT : m_all;
    out_valid_d = in_valid;
    cmp_res = fp16_cmp(cmp_a, cmp_b);
    gt_d = cmp_res[1];
    eq_d = cmp_res[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      max_q       <= 16'h0000;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      max_q       <= max_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign max_out   = max_q;
  assign a_gt_b    = gt_q;
  assign a_eq_b    = eq_q;

endmodule

// File: tb/tb_fp16_max4_pool.sv
// Directed self-checking bench for fp16_max4_pool: compare port, max tree,
// NaN handling, tie priority, reset priority and back-to-back throughput.
module tb_fp16_max4_pool;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] n1, n2, n3, n4;
  logic        out_valid;
  logic [15:0] max_out;
  logic [15:0] cmp_a, cmp_b;
  logic        a_gt_b, a_eq_b;

  int tests_run;
  int tests_failed;

  fp16_max4_pool dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .n1(n1), .n2(n2), .n3(n3), .n4(n4),
    .out_valid(out_valid), .max_out(max_out),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    n1 = 16'h4000; n2 = 16'h4000; n3 = 16'h4000; n4 = 16'h4000;
    cmp_a = 16'h4000; cmp_b = 16'h3C00;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || max_out !== 16'h0000 || a_gt_b !== 1'b0 || a_eq_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got v=%b max=%h gt=%b eq=%b, want v=0 max=0000 gt=0 eq=0",
               out_valid, max_out, a_gt_b, a_eq_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_cmp();
    logic [15:0] va [10] = '{16'h3C00, 16'hC000, 16'h3C00, 16'h0000, 16'h7C00,
                             16'h7E00, 16'h0001, 16'h8001, 16'h4000, 16'h3C00};
    logic [15:0] vb [10] = '{16'h4000, 16'hBC00, 16'hBC00, 16'h8000, 16'h4000,
                             16'h3C00, 16'h1400, 16'h8002, 16'h4000, 16'h7C01};
    logic        eg [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ee [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cmp_a = va[i]; cmp_b = vb[i];
      step();
      tests_run++;
      if (a_gt_b !== eg[i] || a_eq_b !== ee[i]) begin
        tests_failed++;
        $display("FAIL cmp[%0d] %h vs %h: got gt=%b eq=%b, want gt=%b eq=%b",
                 i, va[i], vb[i], a_gt_b, a_eq_b, eg[i], ee[i]);
      end
    end
  endtask

  task automatic run_max(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d, input logic [15:0] exp);
    n1 = a; n2 = b; n3 = c; n4 = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || max_out !== exp) begin
      tests_failed++;
      $display("FAIL %s: got v=%b max=%h, want v=1 max=%h", name, out_valid, max_out, exp);
    end
  endtask

  task automatic test_max();
    run_max("max_inf",   16'h3C00, 16'h4000, 16'hC000, 16'h7C00, 16'h7C00);
    run_max("max_n1",    16'h5000, 16'h4000, 16'hC000, 16'h3C00, 16'h5000);
    run_max("max_neg",   16'hC400, 16'hC800, 16'hC200, 16'hCC00, 16'hC200);
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_drop: got v=%b, want v=0", out_valid);
    end
  endtask

  task automatic test_nan();
    run_max("nan_ignored", 16'h3C00, 16'hBC00, 16'h7E00, 16'h3400, 16'h3C00);
    run_max("all_nan",     16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00);
    run_max("all_nan_mix", 16'h7C01, 16'hFFFF, 16'hFE00, 16'h7D00, 16'h7E00);
    run_max("nan_n1",      16'h7E01, 16'hC000, 16'h7FFF, 16'hBC00, 16'hBC00);
    run_max("nan_neginf",  16'hFE00, 16'h7D00, 16'h7C01, 16'hFC00, 16'hFC00);
  endtask

  task automatic test_ties();
    run_max("tie_zero",  16'h8000, 16'h0000, 16'hFC00, 16'hFC00, 16'h8000);
    run_max("tie_neg",   16'hC000, 16'hC400, 16'hBC00, 16'hC200, 16'hBC00);
    run_max("tie_zero2", 16'hC000, 16'hC000, 16'h0000, 16'h8000, 16'h0000);
    run_max("subnormal", 16'h0001, 16'h8003, 16'h0002, 16'h0000, 16'h0002);
  endtask

  task automatic test_reset_priority();
    n1 = 16'h4000; n2 = 16'h3C00; n3 = 16'h3C00; n4 = 16'h3C00;
    cmp_a = 16'h4000; cmp_b = 16'h4000; in_valid = 1'b1;
    step();
    rst = 1'b1;
    cmp_a = 16'h4000; cmp_b = 16'h3C00;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || max_out !== 16'h0000 || a_gt_b !== 1'b0 || a_eq_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_priority: got v=%b max=%h gt=%b eq=%b, want v=0 max=0000 gt=0 eq=0",
               out_valid, max_out, a_gt_b, a_eq_b);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] s1 [4] = '{16'h3C00, 16'hC000, 16'h7E00, 16'h0000};
    logic [15:0] s2 [4] = '{16'h4000, 16'hC400, 16'h7E00, 16'h8000};
    logic [15:0] s3 [4] = '{16'h4200, 16'hBC00, 16'h7E00, 16'h3400};
    logic [15:0] s4 [4] = '{16'h4100, 16'hC200, 16'h3800, 16'hB400};
    logic [15:0] ex [4] = '{16'h4200, 16'hBC00, 16'h3800, 16'h3400};
    for (int i = 0; i < 4; i++) begin
      n1 = s1[i]; n2 = s2[i]; n3 = s3[i]; n4 = s4[i]; in_valid = 1'b1;
      step();
      tests_run++;
      if (out_valid !== 1'b1 || max_out !== ex[i]) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: got v=%b max=%h, want v=1 max=%h", i, out_valid, max_out, ex[i]);
      end
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: got v=%b, want v=0", out_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0;
    n1 = '0; n2 = '0; n3 = '0; n4 = '0; cmp_a = '0; cmp_b = '0;
    test_reset();
    test_cmp();
    test_max();
    test_nan();
    test_ties();
    test_reset_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
